// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: fetches code bytes over a request/ack bus into a
// DEPTH-byte circular buffer and shows the oldest three bytes to pre-decode.
module prefetch_queue #(
  parameter int unsigned DEPTH      = 6,
  parameter logic [19:0] RESET_ADDR = 20'hFFFF0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ce,
  input  logic        flush,
  input  logic [19:0] flush_addr,
  input  logic        consume,
  input  logic [3:0]  consume_len,
  output logic        fetch_req,
  output logic [19:0] fetch_addr,
  input  logic        fetch_ack,
  input  logic [15:0] fetch_data,
  output logic [3:0]  q_len,
  output logic [7:0]  q0,
  output logic [7:0]  q1,
  output logic [7:0]  q2,
  output logic [19:0] head_addr
);

  localparam int         PW      = $clog2(DEPTH);
  localparam logic [3:0] DEPTH_L = 4'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DISCARD} state_t;

  state_t          r_state;
  logic [7:0]      r_mem [DEPTH];
  logic [PW-1:0]   r_rd_ptr;
  logic [PW-1:0]   r_wr_ptr;
  logic [3:0]      r_count;
  logic [19:0]     r_nfa;
  logic [19:0]     r_head_addr;
  logic [19:0]     r_fetch_addr;
  logic            r_fetch_req;

  logic [3:0]      w_cons_len;
  logic [3:0]      w_count_post;
  logic [3:0]      w_space_need;
  logic            w_space_ok;
  logic            w_fill;
  logic            w_odd;
  logic [3:0]      w_wr_len;

  // Pointer advance modulo DEPTH; n never exceeds DEPTH so one correction suffices.
  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [3:0] n);
    return ((5'(p) + 5'(n)) >= 5'(DEPTH)) ? PW'(5'(p) + 5'(n) - 5'(DEPTH))
                                          : PW'(5'(p) + 5'(n));
  endfunction

  // An over-long consume is clamped to what is actually buffered.
  assign w_cons_len   = !consume ? 4'd0 : ((consume_len > r_count) ? r_count : consume_len);
  assign w_count_post = r_count - w_cons_len;
  assign w_space_need = r_nfa[0] ? 4'd1 : 4'd2;
  assign w_space_ok   = (DEPTH_L - w_count_post) >= w_space_need;
  assign w_fill       = (r_state == S_REQ) && fetch_ack && !flush;
  assign w_odd        = r_fetch_addr[0];
  assign w_wr_len     = !w_fill ? 4'd0 : (w_odd ? 4'd1 : 4'd2);

  // NOTE: storage is not reset; bytes beyond r_count are masked on the outputs,
  // so stale contents are never observable and the array stays plain RAM.
  always_ff @(posedge clk) begin
    if (ce && w_fill) begin
      if (w_odd) begin
        r_mem[r_wr_ptr] <= fetch_data[15:8];
      end else begin
        r_mem[r_wr_ptr]                <= fetch_data[7:0];
        r_mem[ptr_add(r_wr_ptr, 4'd1)] <= fetch_data[15:8];
      end
    end
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, whatever the statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_count      <= 4'd0;
      r_nfa        <= RESET_ADDR;
      r_head_addr  <= RESET_ADDR;
      r_fetch_addr <= RESET_ADDR;
      r_fetch_req  <= 1'b0;
    end else if (ce) begin
      if (flush) begin
        r_count     <= 4'd0;
        r_rd_ptr    <= '0;
        r_wr_ptr    <= '0;
        r_nfa       <= flush_addr;
        r_head_addr <= flush_addr;
        // An unacked request must still complete on the bus; its data is dropped.
        if (r_fetch_req && !fetch_ack) begin
          r_state <= S_DISCARD;
        end else begin
          r_state     <= S_IDLE;
          r_fetch_req <= 1'b0;
        end
      end else begin
        r_rd_ptr    <= ptr_add(r_rd_ptr, w_cons_len);
        r_head_addr <= r_head_addr + 20'(w_cons_len);
        r_count     <= w_count_post + w_wr_len;
        unique case (r_state)
          S_IDLE: begin
            if (w_space_ok) begin
              r_fetch_req  <= 1'b1;
              r_fetch_addr <= r_nfa;
              r_state      <= S_REQ;
            end
          end
          S_REQ: begin
            if (fetch_ack) begin
              r_wr_ptr    <= ptr_add(r_wr_ptr, w_wr_len);
              r_nfa       <= r_nfa + 20'(w_wr_len);
              r_fetch_req <= 1'b0;
              r_state     <= S_IDLE;
            end
          end
          S_DISCARD: begin
            if (fetch_ack) begin
              r_fetch_req <= 1'b0;
              r_state     <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign fetch_req  = r_fetch_req;
  assign fetch_addr = r_fetch_addr;
  assign q_len      = r_count;
  assign head_addr  = r_head_addr;
  assign q0 = (r_count > 4'd0) ? r_mem[r_rd_ptr]                : 8'h00;
  assign q1 = (r_count > 4'd1) ? r_mem[ptr_add(r_rd_ptr, 4'd1)] : 8'h00;
  assign q2 = (r_count > 4'd2) ? r_mem[ptr_add(r_rd_ptr, 4'd2)] : 8'h00;

endmodule

// File: doc/prefetch_queue.md
# prefetch_queue

Instruction prefetch queue and fetch sequencer for the NEC core front end. It issues code-fetch requests to the bus interface and buffers returned bytes in a circular queue. It presents the oldest three bytes plus a byte count to the pre-decode stage, and retires bytes when the decoder consumes an instruction. A flush discards queue contents on branches and interrupts, and redirects fetching.

## Interface
- DEPTH, 6, queue capacity in bytes; legal range 4..15.
- RESET_ADDR, 20'hFFFF0, linear fetch address after reset.

- clk  in  1  core clock
- reset_n  in  1  asynchronous, active-low reset
- ce  in  1  clock enable; all state updates, and sampling of every input, only on clk edges with ce=1
- flush  in  1  discard queue and redirect fetch
- flush_addr  in  20  new linear fetch address, valid with flush
- consume  in  1  decoder retires consume_len bytes from queue head
- consume_len  in  4  bytes retired; 1..q_len
- fetch_req  out  1  code fetch request to bus interface
- fetch_addr  out  20  word address of request; bit0 set means only the high byte is wanted
- fetch_ack  in  1  bus completed request; fetch_data valid this cycle
- fetch_data  in  16  little-endian fetched word
- q_len  out  4  bytes currently buffered
- q0, q1, q2  out  8 each  queue bytes at head, head+1, head+2; 8'h00 where the index is at or beyond q_len
- head_addr  out  20  linear address of q0

## Operation
- Storage is a DEPTH-byte circular buffer with rd_ptr and wr_ptr, each wrapping modulo DEPTH, plus a count register driving q_len.
- The next fetch address (nfa) is the address of the next byte to be requested.
- Request rule:
  - Space needed is 1 if nfa[0]=1, otherwise 2.
  - In IDLE, if DEPTH-q_len ≥ space needed, drive fetch_req=1 and fetch_addr=nfa, and enter REQ.
  - The space check uses post-consume occupancy of the same cycle.
- Handshake: fetch_req and fetch_addr stay stable until a ce cycle with fetch_ack=1. fetch_ack while fetch_req=0 is ignored.
- Ack in REQ:
  - Even address: write data[7:0] then data[15:8]; nfa += 2.
  - Odd address: write data[15:8] only; nfa += 1.
  - count += bytes written - consumed bytes.
  - Go to IDLE. A back-to-back request is allowed starting the next ce cycle.
- Consume: rd_ptr += consume_len and head_addr += consume_len. consume_len > q_len is a protocol error; the block clamps it to q_len.
- Flush has highest priority:
  - count=0, rd_ptr=wr_ptr=0, head_addr=nfa=flush_addr.
  - Consume and ack data in the same cycle are dropped.
  - If a request is outstanding and not acked this cycle, go to DISCARD. Otherwise go to IDLE.
- DISCARD state:
  - Hold fetch_req with the old fetch_addr until ack, then drop the data and go to IDLE.
  - A second flush while in DISCARD only updates nfa and head_addr.
- States: IDLE→REQ (space available, no flush); REQ→IDLE (ack or flush+ack); REQ→DISCARD (flush without ack); DISCARD→IDLE (ack).
- Address arithmetic is 20-bit and wraps from FFFFF to 00000.

## Timing
- Reset values (asynchronous): q_len=0, q0..q2=8'h00, fetch_req=0, fetch_addr=RESET_ADDR, head_addr=RESET_ADDR, state IDLE, pointers 0.
- q_len, head_addr, fetch_req and fetch_addr are registered.
- q0..q2 are combinational reads of storage selected by registered rd_ptr and count, so they are valid in the same cycle as q_len.
- Ack to bytes visible in q_len: 1 ce cycle.
- First fetch_req after reset or flush: 1 ce cycle.
- Flush to q_len=0: 1 ce cycle.
- With ce=0, all outputs hold their values and inputs are ignored.
- Asserting reset mid-request drops fetch_req immediately. The bus interface is responsible for abandoning the cycle.

## Test plan
- Reset: release reset_n → first ce edge: fetch_req=1, fetch_addr=FFFF0. Ack with data 16'hEAB8 → q_len=2, q0=B8, q1=EA, q2=00.
- Fill: ack every request with no consume → q_len steps 2, 4, 6. fetch_req stays 0 at q_len=6. Consume 2 → request resumes at FFFF6.
- Odd redirect: flush with flush_addr=12345 → fetch_addr=12345. Ack 16'hAA55 → q_len=1, q0=AA. Next fetch_addr=12346.
- Flush during outstanding request: flush to 00100 before ack → q_len=0, fetch_req stays at the old address. Ack data is dropped. Next request is to 00100.
- Simultaneous events: q_len=5 with consume 3 and even ack in the same cycle → q_len=4, and pointer wrap is correct. Flush plus consume plus ack in one cycle → q_len=0.
- ce gating: toggle ce at 50% during fill and consume → results identical to the ce=1 run, counted in ce cycles.
